rs_dsp_mac_sequencer: RTL and testbench
=======================================

# rs_dsp_mac_sequencer

Sequencer that drives one DSP38 configured as MULTIPLY_ADD_SUB with the output register enabled and the input register disabled. It computes a dot product of `len` operand pairs taken from a valid/ready stream. It issues each pair to the DSP with the correct accumulator load and feedback controls, waits out the DSP pipeline, and returns the 38-bit accumulated result on a valid/ready result port. It sits between a requester (filter or dot-product engine) and the DSP38 MULTADD_REGOUT instance.

## Interface
- `DSP_LAT`, default 1, cycles from DSP input to valid `z` (output register); legal range 1..3.
- `LEN_W`, default 8, width of the vector-length field.
- `clk`  in  1  clock; all logic on the rising edge.
- `lreset`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; accepted only in IDLE.
- `len`  in  LEN_W  number of operand pairs; sampled with `start`.
- `cfg_unsigned_a`, `cfg_unsigned_b`, `cfg_subtract`, `cfg_round`, `cfg_saturate`  in  1 each  per-job DSP modes; sampled with `start`.
- `cfg_shift`  in  6  per-job output right-shift; sampled with `start`.
- `busy`  out  1  high in every state other than IDLE.
- `op_valid`  in  1, `op_ready`  out  1  operand stream handshake.
- `op_a`  in  20, `op_b`  in  18  operand pair.
- `res_valid`  out  1, `res_ready`  in  1  result handshake.
- `res_data`  out  38  accumulated result.
- `dsp_a`  out  20, `dsp_b`  out  18, `dsp_feedback`  out  3, `dsp_load_acc`  out  1  DSP datapath drive.
- `dsp_unsigned_a`, `dsp_unsigned_b`, `dsp_subtract`, `dsp_round`, `dsp_saturate`  out  1 each, `dsp_shift_right`  out  6  DSP mode drive.
- `dsp_z`  in  38  DSP output.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - On `start`, latch `len` and all `cfg_*` into job registers, then drive them onto the `dsp_*` mode outputs for the whole job.
  - `len`≠0 moves to RUN; `len`=0 moves to DONE with `res_data`=0.
- **RUN:**
  - `op_ready`=1.
  - Each handshake (`op_valid`&`op_ready`) registers `op_a`/`op_b` onto `dsp_a`/`dsp_b` and sets `dsp_load_acc`=1.
  - `dsp_feedback`=3'd1 (clear accumulator, load product) for the first pair of a job, and 3'd0 (accumulate) for every later pair.
  - Issue counter increments on each handshake. The handshake that makes issued==`len` moves the FSM to DRAIN.
- **Bubble:** a RUN cycle without a handshake drives `dsp_load_acc`=0 and `dsp_a`=`dsp_b`=0. The accumulator holds.
- **DRAIN:**
  - `op_ready`=0, `dsp_load_acc`=0.
  - Counts DSP_LAT+1 cycles, then captures `dsp_z` into `res_data` and moves to DONE.
- **DONE:**
  - `res_valid`=1 and `res_data` stable until `res_ready`.
  - On the handshake, return to IDLE.
- **Start in other states:** `start` outside IDLE is ignored; there is no queueing.
- **Arithmetic:** signedness, subtract, round, shift and saturate are performed by the DSP. The sequencer never modifies `dsp_z`.
- **Issue counter:** LEN_W bits; it cannot wrap because it stops at `len`.

## Timing
- **Reset values:** every output is 0 during and after reset, and the FSM is in IDLE. This covers `op_ready`, `res_valid`, `res_data`, `busy` and all `dsp_*` outputs, including `dsp_feedback`=0 and `dsp_load_acc`=0.
- **Reset mid-job:** abandons the job, returns to IDLE and clears all outputs. No result is produced.
- **Start:** `start` at cycle s raises `busy` and, when `len`≠0, `op_ready` at s+1.
- **`len`=0:** `res_valid` at s+1.
- **Per-pair pipeline:** a handshake at cycle t drives `dsp_a`/`dsp_b`/`dsp_load_acc` during t+1. The DSP result reflects that pair at t+1+DSP_LAT.
- **Result latency:** with the last handshake at cycle t, `res_valid` rises at t+DSP_LAT+2.
- **Throughput:** one pair per cycle with no bubbles. A back-to-back job can `start` in the cycle after the result handshake.
- **Backpressure:** `op_ready` is registered state only and does not depend combinationally on `op_valid`. `res_valid` stays high under `res_ready`=0 for any number of cycles.

## Test plan
- **Signed dot product:** `len`=3, signed, pairs (2,3),(4,5),(-1,7), no gaps → `dsp_feedback` 1,0,0; `res_data`=19; `res_valid` 3 cycles after the last handshake with DSP_LAT=1.
- **Bubbles:** same vector as above with `op_valid` low for 2 cycles between pairs → `dsp_load_acc`=0 on bubble cycles; `res_data`=19.
- **Empty job and result backpressure:** `len`=0 → `res_valid` one cycle after `start` with `res_data`=0. Hold `res_ready` low 5 cycles → `res_valid` and `res_data` stay stable; `busy` stays 1.
- **Start while busy:** pulse `start` with `len`=5 during RUN of a `len`=2 job → ignored; the result equals the 2-pair sum; the FSM returns to IDLE.
- **Reset mid-job:** assert `lreset` low after 1 of 4 pairs → all outputs 0 immediately. A new `len`=1 job (3,3) afterwards yields 9 with `dsp_feedback`=1.
- **Unsigned and subtract modes:** `cfg_unsigned_a`=`cfg_unsigned_b`=1 with pair (0xFFFFF, 2) → `res_data`=0x1FFFFE. `cfg_subtract`=1 → `dsp_subtract` held at 1 for the whole job and back to its latched value only on the next `start`.

Source files
------------

// File: rtl/rs_dsp_mac_sequencer_if.sv
// Operand stream and result handshake bundle between a requester and the MAC sequencer.
interface rs_dsp_mac_sequencer_if;
  logic        op_valid;
  logic        op_ready;
  logic [19:0] op_a;
  logic [17:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [37:0] res_data;

  modport master (
    output op_valid, op_a, op_b, res_ready,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data
  );
endinterface

// File: rtl/rs_dsp_mac_sequencer.sv
// Dot-product sequencer for a DSP38 MULTADD_REGOUT: issues operand pairs with
// accumulator controls, drains the DSP pipeline and returns the 38-bit sum.
module rs_dsp_mac_sequencer #(
  parameter int unsigned DSP_LAT = 1,
  parameter int unsigned LEN_W   = 8
) (
  input  logic                 clk,
  input  logic                 lreset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 cfg_unsigned_a,
  input  logic                 cfg_unsigned_b,
  input  logic                 cfg_subtract,
  input  logic                 cfg_round,
  input  logic                 cfg_saturate,
  input  logic [5:0]           cfg_shift,
  output logic                 busy,
  rs_dsp_mac_sequencer_if.slave bus,
  output logic [19:0]          dsp_a,
  output logic [17:0]          dsp_b,
  output logic [2:0]           dsp_feedback,
  output logic                 dsp_load_acc,
  output logic                 dsp_unsigned_a,
  output logic                 dsp_unsigned_b,
  output logic                 dsp_subtract,
  output logic                 dsp_round,
  output logic                 dsp_saturate,
  output logic [5:0]           dsp_shift_right,
  input  logic [37:0]          dsp_z
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_fire;
  logic             w_capture;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issued;
  logic [1:0]       r_drain_cnt;
  logic [37:0]      r_res_data;
  logic [19:0]      r_dsp_a;
  logic [17:0]      r_dsp_b;
  logic [2:0]       r_dsp_fb;
  logic             r_dsp_load;
  logic             r_ua;
  logic             r_ub;
  logic             r_sub;
  logic             r_rnd;
  logic             r_sat;
  logic [5:0]       r_shift;

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_fire    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_fire = bus.op_valid;
        if (w_fire && ((r_issued + LEN_W'(1)) == r_len)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // DRAIN spans DSP_LAT+1 cycles so dsp_z already includes the last pair
        if (r_drain_cnt == 2'(DSP_LAT)) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge lreset) begin
    if (!lreset) begin
      r_len       <= '0;
      r_issued    <= '0;
      r_drain_cnt <= '0;
      r_res_data  <= '0;
      r_dsp_a     <= '0;
      r_dsp_b     <= '0;
      r_dsp_fb    <= '0;
      r_dsp_load  <= 1'b0;
      r_ua        <= 1'b0;
      r_ub        <= 1'b0;
      r_sub       <= 1'b0;
      r_rnd       <= 1'b0;
      r_sat       <= 1'b0;
      r_shift     <= '0;
    end else begin
      r_dsp_load  <= w_fire;
      r_dsp_a     <= w_fire ? bus.op_a : '0;
      r_dsp_b     <= w_fire ? bus.op_b : '0;
      r_dsp_fb    <= (w_fire && (r_issued == '0)) ? 3'd1 : 3'd0;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
      if (w_fire) r_issued <= r_issued + LEN_W'(1);
      if (w_capture) r_res_data <= dsp_z;
      if ((r_state == S_IDLE) && start) begin
        r_len      <= len;
        r_issued   <= '0;
        r_res_data <= '0;
        r_ua       <= cfg_unsigned_a;
        r_ub       <= cfg_unsigned_b;
        r_sub      <= cfg_subtract;
        r_rnd      <= cfg_round;
        r_sat      <= cfg_saturate;
        r_shift    <= cfg_shift;
      end
    end
  end

  assign busy            = (r_state != S_IDLE);
  assign bus.op_ready    = (r_state == S_RUN);
  assign bus.res_valid   = (r_state == S_DONE);
  assign bus.res_data    = r_res_data;
  assign dsp_a           = r_dsp_a;
  assign dsp_b           = r_dsp_b;
  assign dsp_feedback    = r_dsp_fb;
  assign dsp_load_acc    = r_dsp_load;
  assign dsp_unsigned_a  = r_ua;
  assign dsp_unsigned_b  = r_ub;
  assign dsp_subtract    = r_sub;
  assign dsp_round       = r_rnd;
  assign dsp_saturate    = r_sat;
  assign dsp_shift_right = r_shift;

endmodule

// File: tb/tb_rs_dsp_mac_sequencer.sv
// Bench for rs_dsp_mac_sequencer: behavioural DSP38 accumulator plus a result scoreboard.
module tb_rs_dsp_mac_sequencer;
  localparam int unsigned DSP_LAT = 1;
  localparam int unsigned LEN_W   = 8;

  logic             clk = 1'b0;
  logic             lreset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             cfg_unsigned_a = 1'b0;
  logic             cfg_unsigned_b = 1'b0;
  logic             cfg_subtract = 1'b0;
  logic             cfg_round = 1'b0;
  logic             cfg_saturate = 1'b0;
  logic [5:0]       cfg_shift = '0;
  logic             busy;
  logic [19:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [2:0]       dsp_feedback;
  logic             dsp_load_acc;
  logic             dsp_unsigned_a;
  logic             dsp_unsigned_b;
  logic             dsp_subtract;
  logic             dsp_round;
  logic             dsp_saturate;
  logic [5:0]       dsp_shift_right;
  logic [37:0]      dsp_z;

  rs_dsp_mac_sequencer_if bus ();

  always #5 clk = ~clk;

  rs_dsp_mac_sequencer #(.DSP_LAT(DSP_LAT), .LEN_W(LEN_W)) u_dut (
    .clk            (clk),
    .lreset         (lreset),
    .start          (start),
    .len            (len),
    .cfg_unsigned_a (cfg_unsigned_a),
    .cfg_unsigned_b (cfg_unsigned_b),
    .cfg_subtract   (cfg_subtract),
    .cfg_round      (cfg_round),
    .cfg_saturate   (cfg_saturate),
    .cfg_shift      (cfg_shift),
    .busy           (busy),
    .bus            (bus),
    .dsp_a          (dsp_a),
    .dsp_b          (dsp_b),
    .dsp_feedback   (dsp_feedback),
    .dsp_load_acc   (dsp_load_acc),
    .dsp_unsigned_a (dsp_unsigned_a),
    .dsp_unsigned_b (dsp_unsigned_b),
    .dsp_subtract   (dsp_subtract),
    .dsp_round      (dsp_round),
    .dsp_saturate   (dsp_saturate),
    .dsp_shift_right(dsp_shift_right),
    .dsp_z          (dsp_z)
  );

  // Behavioural DSP: feedback 1 clears before the product, 0 accumulates.
  logic signed [63:0] m_pa;
  logic signed [63:0] m_pb;
  logic [37:0]        m_prod;
  logic [37:0]        m_nxt;
  logic [37:0]        m_acc;
  logic [37:0]        m_z [DSP_LAT];

  always_comb begin
    m_pa   = dsp_unsigned_a ? 64'(dsp_a) : 64'($signed(dsp_a));
    m_pb   = dsp_unsigned_b ? 64'(dsp_b) : 64'($signed(dsp_b));
    m_prod = 38'(m_pa * m_pb);
    m_nxt  = (dsp_feedback == 3'd1) ? 38'd0 : m_acc;
    m_nxt  = dsp_subtract ? (m_nxt - m_prod) : (m_nxt + m_prod);
  end

  always @(posedge clk) begin
    if (dsp_load_acc) m_acc <= m_nxt;
    m_z[0] <= dsp_load_acc ? m_nxt : m_acc;
    for (int k = 1; k < int'(DSP_LAT); k++) m_z[k] <= m_z[k-1];
  end

  assign dsp_z = m_z[DSP_LAT-1];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [37:0] sb_q[$];
  logic [19:0] va [8];
  logic [17:0] vb [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] dot(input int n, input bit ua, input bit ub, input bit sub);
    logic signed [63:0] acc;
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      pa  = ua ? 64'(va[i]) : 64'($signed(va[i]));
      pb  = ub ? 64'(vb[i]) : 64'($signed(vb[i]));
      acc = sub ? (acc - pa * pb) : (acc + pa * pb);
    end
    return acc[37:0];
  endfunction

  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic run_job(input int n, input int gap, input bit ua, input bit ub,
                         input bit sub, input int hold, input bit spur);
    int          lat;
    logic [37:0] held;
    logic [37:0] exp;
    start          = 1'b1;
    len            = LEN_W'(n);
    cfg_unsigned_a = ua;
    cfg_unsigned_b = ub;
    cfg_subtract   = sub;
    sb_q.push_back(dot(n, ua, ub, sub));
    @(negedge clk);
    start        = 1'b0;
    cfg_subtract = ~sub;
    check("busy_on_start", busy, 1);
    check("sub_latched", dsp_subtract, sub);
    if (n == 0) check("empty_valid", bus.res_valid, 1);
    else        check("ready_on_start", bus.op_ready, 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("bubble_load", dsp_load_acc, 0);
          check("bubble_a", dsp_a, 0);
        end
      end
      bus.op_valid = 1'b1;
      bus.op_a     = va[i];
      bus.op_b     = vb[i];
      if (spur && i == 1) begin
        start = 1'b1;
        len   = LEN_W'(5);
      end
      @(negedge clk);
      bus.op_valid = 1'b0;
      start        = 1'b0;
      check("pair_load", dsp_load_acc, 1);
      check("pair_a", dsp_a, va[i]);
      check("pair_b", dsp_b, vb[i]);
      check("pair_fb", dsp_feedback, (i == 0) ? 1 : 0);
      check("sub_held", dsp_subtract, sub);
    end
    if (n > 0) begin
      lat = 1;
      while (!bus.res_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("res_valid", bus.res_valid, 1);
      check("res_latency", lat, DSP_LAT + 2);
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      exp = sb_q.pop_front();
      check("res_data", bus.res_data, exp);
    end
    held = bus.res_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", bus.res_data, held);
      check("hold_busy", busy, 1);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("idle_after", busy, 0);
    check("valid_drop", bus.res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_op_ready", bus.op_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_fb", dsp_feedback, 0);
    check("rst_load", dsp_load_acc, 0);
    lreset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_a", dsp_a, 0);

    va[0] = 20'd2;  vb[0] = 18'd3;
    va[1] = 20'd4;  vb[1] = 18'd5;
    va[2] = 20'hFFFFF; vb[2] = 18'd7;
    run_job(3, 0, 0, 0, 0, 0, 0);
    run_job(3, 2, 0, 0, 0, 0, 0);
    run_job(0, 0, 0, 0, 0, 5, 0);

    va[0] = 20'd7;     vb[0] = 18'd6;
    va[1] = 20'hFFFFD; vb[1] = 18'd2;
    run_job(2, 0, 0, 0, 0, 0, 1);

    start = 1'b1;
    len   = LEN_W'(4);
    @(negedge clk);
    start        = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_a     = 20'd5;
    bus.op_b     = 18'd5;
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("mid_load", dsp_load_acc, 1);
    lreset = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_op_ready", bus.op_ready, 0);
    check("mrst_res_valid", bus.res_valid, 0);
    check("mrst_res_data", bus.res_data, 0);
    check("mrst_load", dsp_load_acc, 0);
    check("mrst_a", dsp_a, 0);
    check("mrst_b", dsp_b, 0);
    check("mrst_fb", dsp_feedback, 0);
    @(negedge clk);
    lreset = 1'b1;
    @(negedge clk);

    va[0] = 20'd3; vb[0] = 18'd3;
    run_job(1, 0, 0, 0, 0, 0, 0);

    va[0] = 20'hFFFFF; vb[0] = 18'd2;
    run_job(1, 0, 1, 1, 0, 0, 0);

    va[0] = 20'd10; vb[0] = 18'd2;
    va[1] = 20'd3;  vb[1] = 18'd1;
    run_job(2, 0, 0, 0, 1, 2, 0);
    check("sub_idle_hold", dsp_subtract, 1);

    va[0] = 20'd3; vb[0] = 18'd3;
    run_job(1, 0, 0, 0, 0, 0, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
